trng_word_arbiter: RTL

//  Sequences the serial TRNG output stream (trng bit + out_valid) into WORD_W-bit random words
//  and shares them between NUM_REQ consumers with round-robin arbitration.

---
 rtl/trng_word_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/trng_word_arbiter.sv
// trng_word_arbiter: packs the serial TRNG stream into WORD_W-bit words and hands them out round-robin.
// Define TRNG_HEALTH_EN to enable the repetition-count health test and the sticky FAULT state.
module trng_word_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_W      = 16,
    parameter int WARMUP_BITS = 64,
    parameter int REP_LIMIT   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trng_valid,
    input  logic               trng_bit,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WORD_W-1:0]  gnt_data,
    output logic               word_ready,
    output logic               fault
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(WORD_W + 1);
    localparam int WW = $clog2(WARMUP_BITS + 1);
    typedef enum logic [1:0] {WARMUP, FILL, READY, FAULT} state_t;
    state_t              state_q;
    logic [WW-1:0]       warm_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [WORD_W-1:0]   word_q, gnt_data_q;
    logic [PW-1:0]       rr_q, rr_d, win;
    logic [NUM_REQ-1:0]  gnt_q, win_oh;
    logic                word_ready_q, fault_q, fault_hit;
    // Scan downward so the requester closest to rr_q (upward, with wrap) is written last and wins.
    always_comb begin
        win = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(rr_q) + k) % NUM_REQ]) win = PW'((int'(rr_q) + k) % NUM_REQ);
        rr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
        win_oh = NUM_REQ'(1) << win;
    end
`ifdef TRNG_HEALTH_EN
    logic [7:0] run_q, run_d;
    logic       last_q;
    assign run_d     = (trng_bit != last_q) ? 8'd1 : (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    assign fault_hit = trng_valid && state_q != FAULT && run_d == 8'(REP_LIMIT);
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (trng_valid && state_q != FAULT) begin
            run_q  <= run_d;
            last_q <= trng_bit;
        end
    end
`else
    assign fault_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WARMUP;
            warm_q       <= '0;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            rr_q         <= '0;
            gnt_q        <= '0;
            gnt_data_q   <= '0;
            word_ready_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            gnt_q      <= '0;
            gnt_data_q <= '0;
            if (fault_hit) begin
                state_q      <= FAULT;
                word_ready_q <= 1'b0;
                fault_q      <= 1'b1;
            end else begin
                case (state_q)
                    WARMUP: if (trng_valid) begin
                        warm_q <= warm_q + WW'(1);
                        if (warm_q == WW'(WARMUP_BITS - 1)) begin
                            state_q   <= FILL;
                            bit_cnt_q <= '0;
                        end
                    end
                    FILL: if (trng_valid) begin
                        word_q    <= {word_q[WORD_W-2:0], trng_bit};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(WORD_W - 1)) begin
                            state_q      <= READY;
                            word_ready_q <= 1'b1;
                        end
                    end
                    READY: if (|req) begin
                        gnt_q        <= win_oh;
                        gnt_data_q   <= word_q;
                        rr_q         <= rr_d;
                        bit_cnt_q    <= '0;
                        state_q      <= FILL;
                        word_ready_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign gnt        = gnt_q;
    assign gnt_data   = gnt_data_q;
    assign word_ready = word_ready_q;
    assign fault      = fault_q;
endmodule
